// File: rtl/router_reg.sv
// router_reg: 1x3 router datapath register block with header latch, full-stall hold byte and parity check
module router_reg (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full,
  input  logic       detect_add,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       lfd_state,
  input  logic       rst_int_reg,
  output logic       err,
  output logic       parity_done,
  output logic       low_packet_valid,
  output logic [7:0] dout
);
  logic [7:0] header_byte, full_hold_byte, internal_parity, packet_parity;
  always_ff @(posedge clock) begin
    if (resetn) begin
      dout             <= '0;
      err              <= 1'b0;
      parity_done      <= 1'b0;
      low_packet_valid <= 1'b0;
      header_byte      <= '0;
      full_hold_byte   <= '0;
      internal_parity  <= '0;
      packet_parity    <= '0;
    end else begin
      if (detect_add && pkt_valid && data_in[1:0] != 2'b11) header_byte <= data_in;
      if (lfd_state) dout <= header_byte;
      else if (ld_state && !fifo_full) dout <= data_in;
      else if (ld_state) full_hold_byte <= data_in;
      else if (laf_state) dout <= full_hold_byte;
      internal_parity <= detect_add ? 8'h00 :
                         lfd_state ? internal_parity ^ header_byte :
                         (ld_state && pkt_valid && !full_state) ? internal_parity ^ data_in :
                         internal_parity;
      packet_parity <= detect_add ? 8'h00 :
                       (ld_state && !pkt_valid && !fifo_full) ? data_in : packet_parity;
      parity_done <= detect_add ? 1'b0 :
                     ((ld_state && !fifo_full && !pkt_valid) ||
                      (laf_state && low_packet_valid && !parity_done)) ? 1'b1 : parity_done;
      low_packet_valid <= rst_int_reg ? 1'b0 : (ld_state && !pkt_valid) ? 1'b1 : low_packet_valid;
      err <= detect_add ? 1'b0 : parity_done ? (internal_parity != packet_parity) : err;
    end
  end
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: table-driven scoreboard bench for router_reg
module tb_router_reg;
  logic clock = 1'b0, resetn, pkt_valid, fifo_full, detect_add, ld_state, laf_state;
  logic full_state, lfd_state, rst_int_reg, err, parity_done, low_packet_valid;
  logic [7:0] data_in, dout;
  int vectors = 0, miscompares = 0;
  bit done = 1'b0;
  typedef struct {
    string      name;
    logic [8:0] ctl;
    logic [7:0] din;
    logic [7:0] dout;
    logic       err;
    logic       pd;
    logic       lpv;
  } vec_t;
  vec_t tv[$];
  vec_t exp_q[$];
  router_reg dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
    .rst_int_reg(rst_int_reg), .err(err), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .dout(dout)
  );
  always #5 clock = ~clock;
  task automatic add(input string n, input logic [8:0] c, input logic [7:0] di,
                     input logic [7:0] d, input logic e, input logic p, input logic l);
    vec_t v;
    v.name = n; v.ctl = c; v.din = di; v.dout = d; v.err = e; v.pd = p; v.lpv = l;
    tv.push_back(v);
  endtask
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL: timeout waiting for vector run to finish after %0d vectors", vectors);
      $finish;
    end
  end
  initial begin
    vec_t e;
    {detect_add, lfd_state, ld_state, laf_state, full_state, fifo_full, pkt_valid, rst_int_reg} = '0;
    resetn = 1'b1;
    data_in = '0;
    add("reset",        9'b1_0000_0000, 8'h00, 8'h00, 0, 0, 0);
    add("good_hdr",     9'b0_1000_0010, 8'h16, 8'h00, 0, 0, 0);
    add("good_lfd",     9'b0_0100_0010, 8'h01, 8'h16, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add("good_pay", 9'b0_0010_0010, 8'(k), 8'(k), 0, 0, 0);
    add("good_par",     9'b0_0010_0000, 8'h17, 8'h17, 0, 1, 1);
    add("good_err",     9'b0_0000_0000, 8'h00, 8'h17, 0, 1, 1);
    add("rst_int",      9'b0_0000_0001, 8'h00, 8'h17, 0, 1, 0);
    add("bad_hdr",      9'b0_1000_0010, 8'h16, 8'h17, 0, 0, 0);
    add("bad_lfd",      9'b0_0100_0010, 8'h01, 8'h16, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add("bad_pay", 9'b0_0010_0010, 8'(k), 8'(k), 0, 0, 0);
    add("bad_par",      9'b0_0010_0000, 8'h2E, 8'h2E, 0, 1, 1);
    add("bad_err",      9'b0_0000_0000, 8'h00, 8'h2E, 1, 1, 1);
    add("addr3_hdr",    9'b0_1000_0011, 8'h17, 8'h2E, 0, 0, 0);
    add("addr3_lfd",    9'b0_0100_0010, 8'h00, 8'h16, 0, 0, 0);
    add("full_ld",      9'b0_0010_0110, 8'hAA, 8'h16, 0, 0, 0);
    add("full_state",   9'b0_0000_1110, 8'h55, 8'h16, 0, 0, 0);
    add("laf_replay",   9'b0_0001_0000, 8'h00, 8'hAA, 0, 0, 0);
    add("stall_par",    9'b0_0010_0000, 8'hBC, 8'hBC, 0, 1, 1);
    add("stall_err",    9'b0_0000_0000, 8'h00, 8'hBC, 0, 1, 1);
    add("da_clear",     9'b0_1000_0000, 8'h00, 8'hBC, 0, 0, 1);
    add("laf_pd",       9'b0_0001_0000, 8'h00, 8'hAA, 0, 1, 1);
    add("laf_err",      9'b0_0000_0000, 8'h00, 8'hAA, 0, 1, 1);
    add("lfd_over_ld",  9'b0_0110_0010, 8'h33, 8'h16, 0, 1, 1);
    add("lfd_err",      9'b0_0000_0000, 8'h00, 8'h16, 1, 1, 1);
    add("mid_reset",    9'b1_0000_0000, 8'h00, 8'h00, 0, 0, 0);
    add("post_rst_lfd", 9'b0_0100_0000, 8'h00, 8'h00, 0, 0, 0);
    add("rst_int_wins", 9'b0_0010_0001, 8'h00, 8'h00, 0, 1, 0);
    @(posedge clock);
    #1;
    if ({dout, err, parity_done, low_packet_valid} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset state: dout=%h err=%b pd=%b lpv=%b, expected all 0",
               dout, err, parity_done, low_packet_valid);
    end
    foreach (tv[i]) begin
      {resetn, detect_add, lfd_state, ld_state, laf_state, full_state, fifo_full, pkt_valid, rst_int_reg} = tv[i].ctl;
      data_in = tv[i].din;
      exp_q.push_back(tv[i]);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if ({dout, err, parity_done, low_packet_valid} !== {e.dout, e.err, e.pd, e.lpv}) begin
        miscompares++;
        $display("FAIL vec %0d %s: got dout=%h err=%b pd=%b lpv=%b, expected dout=%h err=%b pd=%b lpv=%b",
                 i, e.name, dout, err, parity_done, low_packet_valid, e.dout, e.err, e.pd, e.lpv);
      end
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares == %s", vectors, miscompares,
             miscompares == 0 ? "PASS" : "FAIL");
    $finish;
  end
endmodule
